// File: rtl/channel_arbiter_pkg.sv
// rtl/channel_arbiter_pkg.sv - shared widths, types and helpers for channel_arbiter_mux
package channel_arbiter_pkg;

   // Width of every per-channel statistics counter
   localparam int STAT_W = 16;

   typedef logic [STAT_W-1:0] stat_cnt_t;

   // Saturation value of a statistics counter
   localparam stat_cnt_t STAT_MAX = '1;

   // Output register occupancy
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Channel index width: clog2 with a floor of one bit so NUM_CH=1 still has a port
   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/channel_arbiter_mux_rr_arbiter.sv
// rtl/channel_arbiter_mux_rr_arbiter.sv - round-robin one-hot grant search starting after last_grant
module rr_arbiter
   import channel_arbiter_pkg::*;
#(
   parameter int  NUM_CH = 2,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   last_grant,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx,
   output logic              any_grant
);

   // Walk the channels from last_grant+1 upward with wrap; the first requester wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         int c;
         c = (int'(last_grant) + k) % NUM_CH;
         if (!any_grant && req[c]) begin
            grant[c]  = 1'b1;
            grant_idx = CH_W'(c);
            any_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/channel_arbiter_mux.sv
// rtl/channel_arbiter_mux.sv - N-channel round-robin merge onto one registered tagged output; optional stats via CHANNEL_ARBITER_MUX_STATS_EN
module channel_arbiter_mux
   import channel_arbiter_pkg::*;
#(
   parameter int  NUM_CH     = 2,
   parameter int  DATA_WIDTH = 4,
   localparam int CH_W       = ch_width(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]              out_ch,
   output logic                         busy
`ifdef CHANNEL_ARBITER_MUX_STATS_EN
   ,
   output logic [NUM_CH*STAT_W-1:0]     stat_count
`endif
);

   out_state_t             state, state_nxt;
   logic [CH_W-1:0]        last_grant;
   logic [NUM_CH-1:0]      grant;
   logic [CH_W-1:0]        grant_idx;
   logic                   any_grant;
   logic                   load_ok;
   logic                   xfer;
   logic [DATA_WIDTH-1:0]  sel_data;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req        (in_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_grant  (any_grant)
   );

   assign out_valid = (state == OUT_FULL);
   assign load_ok   = !out_valid || out_ready;
   // rst gates in_ready so no producer sees an accept while the block is held in reset
   assign in_ready  = grant & {NUM_CH{load_ok && !rst}};
   assign xfer      = any_grant && load_ok;
   assign busy      = (|in_valid) || out_valid;

   // Select the granted channel's payload (grant is one-hot)
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Output register occupancy state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next occupancy: a load always fills; a completed drain without a load empties
   always_comb begin
      state_nxt = state;
      case (state)
         OUT_EMPTY: if (xfer) state_nxt = OUT_FULL;
         OUT_FULL:  if (xfer) state_nxt = OUT_FULL;
                    else if (out_ready) state_nxt = OUT_EMPTY;
         default:   state_nxt = OUT_EMPTY;
      endcase
   end

   // Capture payload, source tag and round-robin pointer on each input transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data   <= '0;
         out_ch     <= '0;
         last_grant <= CH_W'(NUM_CH - 1);
      end else if (xfer) begin
         out_data   <= sel_data;
         out_ch     <= grant_idx;
         last_grant <= grant_idx;
      end
   end

`ifdef CHANNEL_ARBITER_MUX_STATS_EN
   stat_cnt_t stat_cnt [NUM_CH];

   // Per-channel transfer counters, saturating at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            stat_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid[i] && in_ready[i] && stat_cnt[i] != STAT_MAX) begin
               stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
      assign stat_count[g*STAT_W +: STAT_W] = stat_cnt[g];
   end
`endif

endmodule

// File: tb/tb_channel_arbiter_mux.sv
// tb/tb_channel_arbiter_mux.sv - self-checking bench for channel_arbiter_mux with a behavioural reference model
module tb_channel_arbiter_mux;

   localparam int N  = 4;
   localparam int DW = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [N*DW-1:0] in_data = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [DW-1:0]  out_data;
   logic [1:0]     out_ch;
   logic           busy;
`ifdef CHANNEL_ARBITER_MUX_STATS_EN
   logic [N*16-1:0] stat_count;
`endif

   int npass = 0;
   int nchk  = 0;

   // reference model state
   bit       m_valid;
   int       m_data;
   int       m_ch;
   int       m_last;
   int       m_cnt [N];

   always #5 clk = ~clk;

   channel_arbiter_mux #(
      .NUM_CH     (N),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ch     (out_ch),
      .busy       (busy)
`ifdef CHANNEL_ARBITER_MUX_STATS_EN
      ,
      .stat_count (stat_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 0;
      m_ch    = 0;
      m_last  = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   // One clock: drive inputs, check combinational outputs, clock, check registered outputs
   task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic ordy);
      bit load;
      int win;
      logic [N-1:0] exp_ready;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      load = !m_valid || ordy;
      win  = -1;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last + k) % N;
         if (win < 0 && v[c]) win = c;
      end
      exp_ready = (load && win >= 0) ? N'(1 << win) : '0;
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, (v != 0) || m_valid);
      @(posedge clk);
      if (load && win >= 0) begin
         m_valid = 1'b1;
         m_data  = d[win*DW +: DW];
         m_ch    = win;
         m_last  = win;
         m_cnt[win]++;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_ch", out_ch, m_ch);
   endtask

   initial begin
      // reset with all channels requesting: nothing may be accepted
      in_valid = '1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      model_reset();

      // fair rotation over all four channels
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, 32'h13121110, 1'b1);
         chk("rot_ch", out_ch, i % N);
         chk("rot_data", out_data, 8'h10 + (i % N));
      end

      // backpressure on a ch2 beat, then release goes to ch3
      cycle(4'b0100, 32'h00A50000, 1'b1);
      chk("bp_first_ch", out_ch, 2);
      for (int i = 0; i < 3; i++) begin
         cycle(4'b1111, 32'h44332211, 1'b0);
         chk("bp_hold_data", out_data, 8'hA5);
         chk("bp_hold_ch", out_ch, 2);
      end
      cycle(4'b1111, 32'h44332211, 1'b1);
      chk("bp_release_ch", out_ch, 3);

      // sparse requests stream back-to-back
      cycle(4'b0010, 32'h0000B100, 1'b1);
      chk("sparse_ch_a", out_ch, 1);
      cycle(4'b1000, 32'hB3000000, 1'b1);
      chk("sparse_ch_b", out_ch, 3);
      cycle(4'b0010, 32'h0000B200, 1'b1);
      chk("sparse_ch_c", out_ch, 1);
      chk("sparse_valid", out_valid, 1);

      // reset while a beat is stalled
      cycle(4'b0001, 32'h0000003C, 1'b1);
      cycle(4'b0000, 32'h0, 1'b0);
      chk("stall_data", out_data, 8'h3C);
      in_valid = 4'b1111;
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle(4'b1111, 32'h13121110, 1'b1);
      chk("post_rst_ch", out_ch, 0);

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         cycle(N'($urandom_range(0, 15)), $urandom(), ($urandom_range(0, 3) != 0));
      end

`ifdef CHANNEL_ARBITER_MUX_STATS_EN
      for (int i = 0; i < N; i++) begin
         chk("stat_count", stat_count[i*16 +: 16], m_cnt[i]);
      end
`endif

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
